// File: rtl/adder_result_accumulator.sv
// Accumulates {C4,Sum} results from an upstream 4-bit adder over a run of
// n_samples valid cycles, saturating at the top of the accumulator range.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last run's results
// ACCUM | adding each valid operand until count reaches the target
// DONE  | one-cycle completion pulse, then back to IDLE
module adder_result_accumulator #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       n_samples,
  input  logic             in_valid,
  input  logic [3:0]       Sum,
  input  logic             C4,
  output logic [ACC_W-1:0] acc_out,
  output logic [4:0]       count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       target;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_ext;
  logic             take_start;
  logic             accept;
  logic             last;

  assign operand    = {{(ACC_W-5){1'b0}}, C4, Sum};
  assign sum_ext    = {1'b0, acc_out} + {1'b0, operand};
  assign take_start = (state == IDLE) && start;
  assign accept     = (state == ACCUM) && in_valid;
  assign last       = accept && ((count + 5'd1) == target);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // n_samples of 0 encodes a full run of 16
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
      count   <= 5'd0;
      ovf     <= 1'b0;
      target  <= 5'd16;
    end else if (take_start) begin
      acc_out <= '0;
      count   <= 5'd0;
      ovf     <= 1'b0;
      target  <= (n_samples == 4'd0) ? 5'd16 : {1'b0, n_samples};
    end else if (accept) begin
      count <= count + 5'd1;
      if (sum_ext[ACC_W]) begin
        acc_out <= '1;
        ovf     <= 1'b1;
      end else begin
        acc_out <= sum_ext[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Randomized and directed checks of adder_result_accumulator against a
// run-level behavioural model (saturating integer sum, remaining-sample count).
module tb_adder_result_accumulator;

  localparam int ACC_W = 8;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, C4;
  logic [3:0]       n_samples, Sum;
  logic [ACC_W-1:0] acc_out;
  logic [4:0]       count;
  logic             busy, done, ovf;

  int checks = 0;
  int errors = 0;

  // model state: a run is either active, just finished, or not present
  int m_acc, m_cnt, m_target;
  bit m_ovf, m_running, m_finished;
  int done_seen;

  always #5 clk = ~clk;

  adder_result_accumulator #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .Sum(Sum), .C4(C4), .acc_out(acc_out),
    .count(count), .busy(busy), .done(done), .ovf(ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_running = 0; m_finished = 0;
    end else if (m_finished) begin
      m_finished = 0;
    end else if (m_running) begin
      if (in_valid) begin
        int s;
        s = m_acc + int'({C4, Sum});
        if (s > MAXV) begin
          m_acc = MAXV;
          m_ovf = 1;
        end else begin
          m_acc = s;
        end
        m_cnt++;
        if (m_cnt == m_target) begin
          m_running  = 0;
          m_finished = 1;
        end
      end
    end else if (start) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_running = 1;
      m_target = (n_samples == 0) ? 16 : int'(n_samples);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (done) done_seen++;
    chk("acc_out", int'(acc_out), m_acc);
    chk("count",   int'(count),   m_cnt);
    chk("ovf",     int'(ovf),     int'(m_ovf));
    chk("busy",    int'(busy),    int'(m_running));
    chk("done",    int'(done),    int'(m_finished));
  endtask

  task automatic drive(input bit s, input bit v, input int sm, input bit c);
    start = s; in_valid = v; Sum = 4'(sm); C4 = c;
  endtask

  task automatic do_reset();
    rst = 1; drive(0, 0, 0, 0);
    cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; Sum = 0; C4 = 0; n_samples = 0;
    done_seen = 0;
    m_acc = 0; m_cnt = 0; m_ovf = 0; m_running = 0; m_finished = 0; m_target = 16;
    #2;
    do_reset();
    chk("reset_acc", int'(acc_out), 0);
    chk("reset_busy", int'(busy), 0);

    // three-sample run: 5 + 31 + 16
    n_samples = 3; drive(1, 0, 0, 0); cycle();
    drive(0, 1, 5, 0);  cycle();
    drive(0, 1, 15, 1); cycle();
    drive(0, 1, 0, 1);  cycle();
    chk("run3_acc", int'(acc_out), 52);
    chk("run3_cnt", int'(count), 3);
    chk("run3_done", int'(done), 1);
    drive(0, 0, 0, 0); cycle();
    chk("run3_done_gone", int'(done), 0);
    chk("run3_busy_low", int'(busy), 0);

    // input ignored in IDLE
    drive(0, 1, 9, 1); cycle();
    chk("idle_ignore_acc", int'(acc_out), 52);
    chk("idle_ignore_cnt", int'(count), 3);

    // sixteen samples of 31 with saturation on the 9th
    n_samples = 0; drive(1, 0, 0, 0); cycle();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 15, 1); cycle();
      if (i == 8) begin
        chk("sat_before_acc", int'(acc_out), 248);
        chk("sat_before_ovf", int'(ovf), 0);
      end
      if (i == 9) begin
        chk("sat_acc", int'(acc_out), 255);
        chk("sat_ovf", int'(ovf), 1);
      end
    end
    chk("sat16_cnt", int'(count), 16);
    chk("sat16_done", int'(done), 1);
    drive(0, 0, 0, 0); cycle();

    // gaps of idle cycles between valid inputs
    n_samples = 2; drive(1, 0, 0, 0); cycle();
    drive(0, 1, 1, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 7, 1); n_samples = 4'(i + 5); cycle();
      chk("gap_busy", int'(busy), 1);
      chk("gap_acc", int'(acc_out), 1);
    end
    drive(0, 1, 2, 0); cycle();
    chk("gap_final_acc", int'(acc_out), 3);
    chk("gap_done", int'(done), 1);
    drive(0, 0, 0, 0); cycle();

    // reset mid-run abandons without done
    n_samples = 4; drive(1, 0, 0, 0); cycle();
    drive(0, 1, 3, 0); cycle();
    chk("mid_cnt_before", int'(count), 1);
    done_seen = 0;
    rst = 1; drive(1, 1, 3, 0); cycle(); rst = 0;
    chk("mid_rst_acc", int'(acc_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    drive(0, 0, 0, 0); cycle(); cycle();
    chk("mid_rst_no_done", done_seen, 0);

    // start held high: back-to-back single-sample runs
    n_samples = 1; drive(1, 1, 4, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) begin
        chk("rep_acc", int'(acc_out), 4);
        chk("rep_cnt", int'(count), 1);
      end
    end
    chk("rep_runs", done_seen, 4);
    drive(0, 0, 0, 0); cycle(); cycle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      Sum       = 4'($urandom_range(0, 15));
      C4        = 1'($urandom_range(0, 1));
      n_samples = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
